sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock first-word-fall-through FIFO that buffers data words between a producer and a consumer running at different rates. It replaces a plain enable-register stage wherever a pipeline stage can stall. It provides full/empty/almost-full status, an occupancy count, and sticky overflow/underflow error flags for debug.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AW (localparam), log2(DEPTH), pointer width
- clk  input  1  rising-edge clock
- rst  input  1  reset rst, synchronous, active-high; clock clk
- wr_en  input  1  push request
- wr_data  input  WIDTH  word to push
- rd_en  input  1  pop request (acknowledges current rd_data)
- rd_data  output  WIDTH  head-of-queue word (FWFT)
- empty  output  1  no entries stored
- full  output  1  DEPTH entries stored
- almost_full  output  1  count ≥ DEPTH-1
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full and not popped
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp and read pointer rp, each AW bits, wrapping modulo DEPTH. Occupancy is held in a registered count of AW+1 bits. full, empty and almost_full decode from count.
- push_ok = wr_en & (!full | rd_en). pop_ok = rd_en & !empty.
- On push_ok: mem[wp] <= wr_data; wp <= wp+1 (DEPTH-1 wraps to 0).
- On pop_ok: rp <= rp+1 (wrapping).
- count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither occur.
- Full with wr_en and rd_en both high: the pop and the push both proceed. count stays at DEPTH and no overflow is flagged.
- Empty with wr_en and rd_en both high: the push proceeds, the pop is ignored, count becomes 1, and underflow sets.
- wr_en while full and rd_en low: data is dropped, the pointers hold, and overflow sets.
- rd_en while empty: nothing changes except that underflow sets.
- overflow and underflow stay set until rst.
- rd_data = mem[rp] when !empty, and 0 when empty.

## Timing
- Reset (rst high at a clock edge): wp=0, rp=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0. Array contents are not reset.
- rst has priority over wr_en/rd_en in the same cycle. Any in-flight push or pop is discarded.
- Write-to-read latency is 1 cycle. A word pushed at edge k appears on rd_data, with empty=0, after edge k.
- A pop at edge k presents the next word, or empty=1, after edge k.
- All status outputs are registered or decoded from registered count only. There is no combinational path from wr_en/rd_en to any output.
- Sustained push+pop every cycle achieves one word per clock at any occupancy from 1 to DEPTH.

## Test plan
- Reset/idle: assert rst for 2 cycles -> empty=1, full=0, count=0, rd_data=0, flags=0. Pulse rd_en once -> underflow=1 and count stays 0.
- Fill/drain order (DEPTH=8): push 0x11..0x88 on 8 consecutive cycles. Result: almost_full=1 at count 7, full=1 at count 8. Then pop 8 times: rd_data sequence 0x11..0x88, and empty=1 after the last pop.
- Overflow: with the FIFO full, push 0xDEAD with rd_en=0 -> overflow=1, count=8, and the 8 stored words are unchanged on drain.
- Simultaneous at full: with 8 entries stored, push 0x99 and pop in the same cycle. Result: count=8, overflow=0, and the drained order ends with 0x99.
- Simultaneous at empty and wrap: push and pop 0x5A in one cycle when empty -> count=1, rd_data=0x5A, underflow=1. Then run 20 cycles of streaming push+pop with incrementing data -> in-order output across pointer wrap, count held at 1.
- Reset mid-operation: with count=5, assert rst together with wr_en and rd_en -> next cycle count=0, empty=1, flags=0. After that, a new push of 0x42 reads back 0x42 first.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head word is always visible on rd_data. rd_en acknowledges (pops) it.
// All status outputs are decoded from registered state only.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST_CNT = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // Status decode from the registered occupancy.
    assign empty       = (cnt == '0);
    assign full        = (cnt == FULL_CNT);
    assign almost_full = (cnt >= ALMOST_CNT);
    assign count       = cnt;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    // Head of queue is visible without a read strobe; zero when nothing is stored.
    assign rd_data = empty ? '0 : mem[rp];

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky debug flags: cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: queue-based scoreboard plus per-scenario status checks.
module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    logic             mov;
    logic             mun;
    logic [WIDTH-1:0] last_pop;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two edges and clear the reference model.
    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mov = 1'b0;
        mun = 1'b0;
    endtask

    // One clock of stimulus; popped words are compared against the scoreboard head.
    task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        logic do_pop;
        logic do_push;
        logic [WIDTH-1:0] exp;
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        do_push = we && ((q.size() < DEPTH) || re);
        do_pop  = re && (q.size() > 0);
        if (we && (q.size() == DEPTH) && !re) mov = 1'b1;
        if (re && (q.size() == 0)) mun = 1'b1;
        if (do_pop) begin
            exp = q.pop_front();
            last_pop = exp;
            checks++;
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL rd_data: got %h expected %h", rd_data, exp);
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (do_push) q.push_back(wd);
        checks++;
        if (count !== 4'(q.size())) begin
            errors++;
            $display("FAIL count_track: got %0d expected %0d", count, q.size());
        end
        checks++;
        if ({overflow, underflow} !== {mov, mun}) begin
            errors++;
            $display("FAIL sticky_flags: got ov=%b un=%b expected ov=%b un=%b",
                     overflow, underflow, mov, mun);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, almost_full} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status: got e/f/af=%b%b%b expected 100", empty, full, almost_full);
        end
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b%b expected 00", overflow, underflow);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (underflow !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL idle_underflow: got un=%b count=%0d expected un=1 count=0", underflow, count);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, WIDTH'(i * 32'h11), 1'b0);
            if (i == 6) begin
                checks++;
                if (almost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL af_at_6: got %b expected 0", almost_full);
                end
            end
            if (i == 7) begin
                checks++;
                if ({almost_full, full} !== 2'b10) begin
                    errors++;
                    $display("FAIL af_at_7: got af=%b full=%b expected af=1 full=0", almost_full, full);
                end
            end
        end
        checks++;
        if ({almost_full, full, empty} !== 3'b110 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_at_8: got af=%b f=%b e=%b count=%0d expected 1 1 0 8",
                     almost_full, full, empty, count);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        checks++;
        if (empty !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL drained_empty: got e=%b rd_data=%h expected e=1 rd_data=0", empty, rd_data);
        end
        checks++;
        if (last_pop !== 32'h88) begin
            errors++;
            $display("FAIL drain_last: got %h expected 88", last_pop);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i * 32'h11), 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: got ov=%b count=%0d expected ov=1 count=8", overflow, count);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        checks++;
        if (last_pop !== 32'h88 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain: got last=%h ov=%b expected last=88 ov=1", last_pop, overflow);
        end
    endtask

    task automatic test_simul_full();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i * 32'h11), 1'b0);
        cycle(1'b1, 32'h99, 1'b1);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL simul_full: got count=%0d ov=%b full=%b expected 8 0 1", count, overflow, full);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        checks++;
        if (last_pop !== 32'h99) begin
            errors++;
            $display("FAIL simul_full_tail: got %h expected 99", last_pop);
        end
    endtask

    task automatic test_empty_wrap();
        do_reset();
        cycle(1'b1, 32'h5A, 1'b1);
        checks++;
        if (count !== 4'd1 || rd_data !== 32'h5A || underflow !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty: got count=%0d rd=%h un=%b expected 1 5a 1", count, rd_data, underflow);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b1);
            checks++;
            if (count !== 4'd1) begin
                errors++;
                $display("FAIL stream_count: got %0d expected 1 at step %0d", count, i);
            end
        end
        checks++;
        if (rd_data !== 32'h113) begin
            errors++;
            $display("FAIL stream_head: got %h expected 113", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, '0, 1'b1);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'h70 + 32'(i), 1'b0);
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d expected 5", count);
        end
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'hBAD;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        mov = 1'b0;
        mun = 1'b0;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d e=%b ov=%b un=%b expected 0 1 0 0",
                     count, empty, overflow, underflow);
        end
        cycle(1'b1, 32'h42, 1'b0);
        checks++;
        if (rd_data !== 32'h42) begin
            errors++;
            $display("FAIL post_reset_head: got %h expected 42", rd_data);
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        mov = 1'b0;
        mun = 1'b0;
        last_pop = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_empty_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
